// File: rtl/code_hist_pkg.sv
// rtl/code_hist_pkg.sv - shared FSM encoding, bin geometry and code-legality helper for code_histogram
package code_hist_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      DUMP  = 1'b1
   } state_e;

   localparam int         NUM_BINS = 5;
   localparam logic [2:0] CODE_MIN = 3'd1;
   localparam logic [2:0] CODE_MAX = 3'd5;

   // Window counter width; WINDOW is limited to 1..255 so 8 bits always suffice.
   localparam int         WIN_W    = 8;

   // A code selects a bin only when it lies inside CODE_MIN..CODE_MAX.
   function automatic logic code_is_legal(input logic [2:0] code);
      return (code >= CODE_MIN) && (code <= CODE_MAX);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Clear wins over increment; increment is suppressed once the counter is full.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/code_histogram.sv
// rtl/code_histogram.sv - windowed histogram of class codes 1..5 with handshaked bin readout
module code_histogram
   import code_hist_pkg::*;
#(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [2:0]       add,
   input  logic             clear,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [2:0]       rd_bin,
   output logic [CNT_W-1:0] rd_count,
   output logic             busy,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

   state_e           state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [2:0]       rd_idx_q, rd_idx_d;

   logic             code_take;
   logic             code_ok;
   logic             last_xfer;
   logic             bins_clr;
   logic [CNT_W-1:0] bin_cnt [NUM_BINS];

   // A code is taken only in ACCUM and only when no clear competes with it.
   assign code_take = (state_q == ACCUM) && in_valid && !clear;
   assign code_ok   = code_is_legal(add);
   assign last_xfer = (state_q == DUMP) && rd_ready && (rd_idx_q == CODE_MAX);
   assign bins_clr  = ((state_q == ACCUM) && clear) || last_xfer;

   // Next-state logic: window counting in ACCUM, bin walk in DUMP.
   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      rd_idx_d = rd_idx_q;
      case (state_q)
         ACCUM: begin
            if (clear) begin
               win_d = '0;
            end else if (in_valid) begin
               win_d = win_q + 1'b1;
               if (win_q == WIN_LAST) begin
                  state_d  = DUMP;
                  rd_idx_d = CODE_MIN;
               end
            end
         end
         DUMP: begin
            if (rd_ready) begin
               if (rd_idx_q == CODE_MAX) begin
                  state_d  = ACCUM;
                  win_d    = '0;
                  rd_idx_d = CODE_MIN;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // State, window counter and readout index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ACCUM;
         win_q    <= '0;
         rd_idx_q <= CODE_MIN;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         rd_idx_q <= rd_idx_d;
      end
   end

   // One saturating counter per bin; bin b holds code b+1.
   for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
      sat_counter #(.WIDTH(CNT_W)) u_bin (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (code_take && code_ok && (add == 3'(b + 1))),
         .clr   (bins_clr),
         .count (bin_cnt[b])
      );
   end

   // Illegal codes persist across windows; only reset clears them.
   sat_counter #(.WIDTH(CNT_W)) u_err (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (code_take && !code_ok),
      .clr   (1'b0),
      .count (err_cnt)
   );

   // Codes arriving while the histogram is being read out are lost.
   sat_counter #(.WIDTH(CNT_W)) u_drop (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ((state_q == DUMP) && in_valid),
      .clr   (1'b0),
      .count (drop_cnt)
   );

   assign rd_valid = (state_q == DUMP);
   assign busy     = (state_q == DUMP);
   assign rd_bin   = rd_valid ? rd_idx_q : 3'd0;

   // Readout mux: selected bin count while valid, zero otherwise.
   always_comb begin
      rd_count = '0;
      if (rd_valid) begin
         for (int b = 0; b < NUM_BINS; b++) begin
            if (rd_idx_q == 3'(b + 1)) begin
               rd_count = bin_cnt[b];
            end
         end
      end
   end

endmodule

// File: tb/tb_code_histogram.sv
// tb/tb_code_histogram.sv - directed self-checking bench for code_histogram
module tb_code_histogram;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, clear, rd_ready;
   logic [2:0] add;
   logic       rd_valid, busy;
   logic [2:0] rd_bin;
   logic [7:0] rd_count, err_cnt, drop_cnt;

   logic       in_valid1, clear1, rd_ready1;
   logic [2:0] add1;
   logic       rd_valid1, busy1;
   logic [2:0] rd_bin1;
   logic [1:0] rd_count1, err_cnt1, drop_cnt1;

   int vectors    = 0;
   int miscompares = 0;
   int exp_cnt [1:5];

   always #5 clk = ~clk;

   code_histogram #(.WINDOW(16), .CNT_W(8)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .add      (add),
      .clear    (clear),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_bin   (rd_bin),
      .rd_count (rd_count),
      .busy     (busy),
      .err_cnt  (err_cnt),
      .drop_cnt (drop_cnt)
   );

   code_histogram #(.WINDOW(1), .CNT_W(2)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid1),
      .add      (add1),
      .clear    (clear1),
      .rd_ready (rd_ready1),
      .rd_valid (rd_valid1),
      .rd_bin   (rd_bin1),
      .rd_count (rd_count1),
      .busy     (busy1),
      .err_cnt  (err_cnt1),
      .drop_cnt (drop_cnt1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input int c);
      in_valid = 1'b1;
      add      = 3'(c);
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_cycle(input int n);
      for (int i = 0; i < n; i++) send((i % 5) + 1);
   endtask

   task automatic set_exp(input int a, input int b, input int c, input int d, input int e);
      exp_cnt[1] = a; exp_cnt[2] = b; exp_cnt[3] = c; exp_cnt[4] = d; exp_cnt[5] = e;
   endtask

   task automatic dump_check(input string tag, input int exp_sum);
      int sum;
      sum      = 0;
      rd_ready = 1'b1;
      for (int b = 1; b <= 5; b++) begin
         chk($sformatf("%s_valid_w%0d", tag, b), 32'(rd_valid), 1);
         chk($sformatf("%s_busy_w%0d", tag, b), 32'(busy), 1);
         chk($sformatf("%s_bin_w%0d", tag, b), 32'(rd_bin), b);
         chk($sformatf("%s_count_w%0d", tag, b), 32'(rd_count), exp_cnt[b]);
         sum += int'(rd_count);
         step();
      end
      chk($sformatf("%s_valid_end", tag), 32'(rd_valid), 0);
      chk($sformatf("%s_busy_end", tag), 32'(busy), 0);
      chk($sformatf("%s_sum", tag), sum, exp_sum);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nb;
      int cyc;

      rst_n     = 1'b0;
      in_valid  = 1'b0; add  = 3'd0; clear  = 1'b0; rd_ready  = 1'b1;
      in_valid1 = 1'b0; add1 = 3'd0; clear1 = 1'b0; rd_ready1 = 1'b1;
      step();
      step();

      // reset state
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_bin", 32'(rd_bin), 0);
      chk("rst_count", 32'(rd_count), 0);
      chk("rst_err", 32'(err_cnt), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      rst_n = 1'b1;
      step();

      // scenario 1: 16 codes cycling 1..5
      send_cycle(15);
      chk("s1_no_early_dump", 32'(rd_valid), 0);
      send(1);
      set_exp(4, 3, 3, 3, 3);
      dump_check("s1", 16);

      // scenario 2: every fourth code illegal (7); bins confirm previous window was zeroed
      for (int i = 0; i < 16; i++) send((i % 4 == 3) ? 7 : (i % 5) + 1);
      chk("s2_err", 32'(err_cnt), 4);
      set_exp(3, 2, 2, 2, 3);
      dump_check("s2", 12);

      // scenario 3: rd_ready pattern 1,0,0,1 during the dump
      send_cycle(16);
      set_exp(4, 3, 3, 3, 3);
      nb  = 1;
      cyc = 0;
      while (nb <= 5 && cyc < 40) begin
         rd_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         chk($sformatf("s3_valid_c%0d", cyc), 32'(rd_valid), 1);
         chk($sformatf("s3_bin_c%0d", cyc), 32'(rd_bin), nb);
         chk($sformatf("s3_count_c%0d", cyc), 32'(rd_count), exp_cnt[nb]);
         if (rd_ready) nb++;
         step();
         cyc++;
      end
      if (nb <= 5) chk("s3_timeout", nb, 6);
      chk("s3_cycles", cyc, 9);
      chk("s3_valid_end", 32'(rd_valid), 0);
      rd_ready = 1'b1;

      // scenario 4: in_valid held high through the dump
      for (int i = 0; i < 16; i++) send(3);
      in_valid = 1'b1;
      add      = 3'd1;
      set_exp(0, 0, 16, 0, 0);
      dump_check("s4", 16);
      in_valid = 1'b0;
      chk("s4_drop", 32'(drop_cnt), 5);
      for (int i = 0; i < 16; i++) send(4);
      set_exp(0, 0, 0, 16, 0);
      dump_check("s4_next", 16);

      // scenario 5: clear coincident with the 11th code
      send_cycle(10);
      in_valid = 1'b1;
      add      = 3'd5;
      clear    = 1'b1;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("s5_no_dump_clear", 32'(rd_valid), 0);
      send_cycle(15);
      chk("s5_no_dump_15", 32'(rd_valid), 0);
      send(1);
      set_exp(4, 3, 3, 3, 3);
      dump_check("s5", 16);
      chk("s5_err_kept", 32'(err_cnt), 4);

      // scenario 6: reset pulsed after the bin-2 transfer
      send_cycle(16);
      chk("s6_w1_bin", 32'(rd_bin), 1);
      step();
      chk("s6_w2_bin", 32'(rd_bin), 2);
      step();
      chk("s6_w3_bin", 32'(rd_bin), 3);
      rst_n = 1'b0;
      #1;
      chk("s6_valid", 32'(rd_valid), 0);
      chk("s6_busy", 32'(busy), 0);
      chk("s6_bin", 32'(rd_bin), 0);
      chk("s6_count", 32'(rd_count), 0);
      chk("s6_err", 32'(err_cnt), 0);
      chk("s6_drop", 32'(drop_cnt), 0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("s6_idle_%0d", i), 32'(rd_valid), 0);
      end
      send_cycle(16);
      set_exp(4, 3, 3, 3, 3);
      dump_check("s6_next", 16);
      chk("s6_err_after", 32'(err_cnt), 0);

      // WINDOW=1, CNT_W=2: single code dumps, and counters saturate at 3
      in_valid1 = 1'b1;
      add1      = 3'd3;
      step();
      in_valid1 = 1'b0;
      for (int b = 1; b <= 5; b++) begin
         chk($sformatf("w1_valid_w%0d", b), 32'(rd_valid1), 1);
         chk($sformatf("w1_bin_w%0d", b), 32'(rd_bin1), b);
         chk($sformatf("w1_count_w%0d", b), 32'(rd_count1), (b == 3) ? 1 : 0);
         step();
      end
      chk("w1_valid_end", 32'(rd_valid1), 0);
      in_valid1 = 1'b1;
      add1      = 3'd6;
      step();
      chk("w1_illegal_dumps", 32'(rd_valid1), 1);
      for (int k = 0; k < 23; k++) step();
      in_valid1 = 1'b0;
      chk("w1_valid_idle", 32'(rd_valid1), 0);
      chk("w1_err_sat", 32'(err_cnt1), 3);
      chk("w1_drop_sat", 32'(drop_cnt1), 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/code_histogram.md
CODE_HISTOGRAM -- requirements
Module: code_histogram

Interface
REQ-001 The block SHALL have parameter WINDOW, default 16, meaning the number of accepted codes per histogram window (legal range 1..255).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of each bin counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port in_valid: input, 1 bit, add carries a code this cycle.
REQ-007 Port add: input, 3 bits, class code from the upstream casex classifier; legal values 1..5.
REQ-008 Port clear: input, 1 bit, synchronous abort of the current window.
REQ-009 Port rd_ready: input, 1 bit, the downstream consumer accepts the readout word.
REQ-010 Port rd_valid: output, 1 bit, the readout word is valid.
REQ-011 Port rd_bin: output, 3 bits, bin index of the readout word (1..5).
REQ-012 Port rd_count: output, CNT_W bits, bin count of the readout word.
REQ-013 Port busy: output, 1 bit, high while in DUMP.
REQ-014 Port err_cnt: output, CNT_W bits, saturating count of illegal codes (0, 6, 7).
REQ-015 Port drop_cnt: output, CNT_W bits, saturating count of codes dropped during DUMP.

Function
REQ-016 The FSM SHALL have two states: ACCUM and DUMP.
REQ-017 In ACCUM, a cycle with in_valid=1 and add in 1..5 SHALL increment bin[add] by 1, saturating at 2^CNT_W-1.
REQ-018 In ACCUM, a cycle with in_valid=1 and add in {0,6,7} SHALL increment err_cnt (saturating) and SHALL leave every bin unchanged.
REQ-019 Every in_valid=1 cycle in ACCUM, legal or illegal, SHALL increment the window counter.
REQ-020 When the window counter reaches WINDOW, the next state SHALL be DUMP, and that final code SHALL be counted.
REQ-021 On entry to DUMP, rd_valid SHALL assert on the following cycle, one cycle after the last code.
REQ-022 In DUMP, the block SHALL present bins 1..5 in ascending order, one word per handshake.
REQ-023 Transfer SHALL occur on rd_valid=1 and rd_ready=1.
REQ-024 rd_bin and rd_count SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-025 After the bin-5 transfer, the block SHALL zero all bins and the window counter, return to ACCUM, and deassert rd_valid in the next cycle.
REQ-026 err_cnt SHALL NOT be zeroed at the end of a window.
REQ-027 In DUMP, in_valid=1 SHALL increment drop_cnt (saturating) and SHALL otherwise be ignored.
REQ-028 clear=1 in ACCUM SHALL zero all bins and the window counter in the next cycle; clear SHALL take priority over a simultaneous code.
REQ-029 clear=1 in DUMP SHALL be ignored; the dump always completes.
REQ-030 With rd_ready held high, a dump SHALL take exactly 5 cycles.
REQ-031 With WINDOW=1, every accepted code SHALL trigger a full dump.

Reset
REQ-032 While rst_n=0, the block SHALL be in ACCUM.
REQ-033 While rst_n=0, all bins, the window counter, err_cnt and drop_cnt SHALL be 0.
REQ-034 While rst_n=0, rd_valid, busy, rd_bin and rd_count SHALL be 0.
REQ-035 Reset asserted mid-dump SHALL abort the dump immediately, with no further readout words.

Structure
REQ-036 Package code_hist_pkg SHALL hold the FSM state encoding.
REQ-037 Package code_hist_pkg SHALL hold NUM_BINS=5, CODE_MIN=1 and CODE_MAX=5.
REQ-038 A sub-module sat_counter (parameter width, with inc, clr and count ports) SHALL implement each bin, err_cnt and drop_cnt.
REQ-039 The top level SHALL hold only the FSM, the window counter and the readout mux.

Verification
REQ-040 Scenario 1: reset, then 16 valid codes cycling 1,2,3,4,5,1... with rd_ready=1 -> readout (1,4),(2,3),(3,3),(4,3),(5,3); busy for 5 cycles; bins then 0.
REQ-041 Scenario 2: 16 codes with every fourth code = 7 -> err_cnt=4, and the bin sum read out = 12.
REQ-042 Scenario 3: rd_ready toggles 1,0,0,1 during a dump -> each word held stable until transferred; no word lost or duplicated.
REQ-043 Scenario 4: in_valid held high through a 5-cycle dump -> drop_cnt=5, and the next window starts from zero counts.
REQ-044 Scenario 5: clear asserted after 10 codes, coincident with a code -> no dump; 16 further codes give a dump whose sum is 16.
REQ-045 Scenario 6: rst_n pulsed low after the bin-2 transfer -> rd_valid=0 immediately; all counters 0; the next window is normal.
